// File: rtl/face_match_pkg.sv
// face_match_pkg: shared states, widths and byte helper for the face-search scheduler.
package face_match_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REF,
        ACCUM,
        PUSH_DIST,
        PUSH_BEST,
        DONE
    } state_e;

    localparam int               ACC_W         = 24;
    localparam logic [ACC_W-1:0] ACC_SAT       = '1;
    localparam logic [15:0]      MIN16_SAT     = 16'hFFFF;
    localparam int               RES_BEST_FLAG = 31;

    function automatic logic [7:0] absdiff8(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? x - y : y - x;
    endfunction

endpackage

// File: rtl/face_sad4.sv
// face_sad4: sum of absolute differences of the four unsigned bytes of two words.
module face_sad4
    import face_match_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [9:0]  sad_o
);

    assign sad_o = 10'(absdiff8(a_i[7:0],   b_i[7:0]))
                 + 10'(absdiff8(a_i[15:8],  b_i[15:8]))
                 + 10'(absdiff8(a_i[23:16], b_i[23:16]))
                 + 10'(absdiff8(a_i[31:24], b_i[31:24]));

endmodule

// File: rtl/face_match_sched.sv
// face_match_sched: loads a reference vector from stream A, pushes the SAD of every
// candidate vector from stream B, then a best-match summary word when B closes.
module face_match_sched
    import face_match_pkg::*;
#(
    parameter int VEC_WORDS = 32,
    parameter int IDX_W     = 15
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic        a_open,
    input  logic        a_empty,
    input  logic [31:0] a_data,
    output logic        a_rden,
    input  logic        b_open,
    input  logic        b_empty,
    input  logic [31:0] b_data,
    output logic        b_rden,
    input  logic        res_open,
    input  logic        res_full,
    output logic        res_wren,
    output logic [31:0] res_data,
    output logic        done
);

    localparam int                WCNT_W = $clog2(VEC_WORDS);
    localparam logic [WCNT_W-1:0] LAST   = WCNT_W'(VEC_WORDS - 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, min_q, min_d;
    logic [IDX_W-1:0]  idx_q, idx_d, best_q, best_d;
    logic              minv_q, minv_d;
    logic [31:0]       ref_ram [VEC_WORDS];
    logic [9:0]        sad;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;
    logic [15:0]       min16;
    logic              last_word;

    face_sad4 u_sad4 (
        .a_i  (b_data),
        .b_i  (ref_ram[wcnt_q]),
        .sad_o(sad)
    );

    assign acc_sum   = {1'b0, acc_q} + (ACC_W + 1)'(sad);
    assign acc_sat   = acc_sum[ACC_W] ? ACC_SAT : acc_sum[ACC_W-1:0];
    assign min16     = |min_q[ACC_W-1:16] ? MIN16_SAT : min_q[15:0];
    assign last_word = wcnt_q == LAST;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        acc_d    = acc_q;
        min_d    = min_q;
        idx_d    = idx_q;
        best_d   = best_q;
        minv_d   = minv_q;
        a_rden   = 1'b0;
        b_rden   = 1'b0;
        res_wren = 1'b0;
        res_data = '0;
        done     = 1'b0;
        // A closed result file aborts any session before anything else can pop or push.
        if (state_q != IDLE && !res_open) begin
            state_d = IDLE;
            {wcnt_d, acc_d, min_d, idx_d, best_d, minv_d} = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    {wcnt_d, acc_d, min_d, idx_d, best_d, minv_d} = '0;
                    state_d = (a_open && res_open) ? LOAD_REF : IDLE;
                end
                LOAD_REF: begin
                    if (!a_open) begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end else if (!a_empty) begin
                        a_rden  = 1'b1;
                        wcnt_d  = last_word ? '0 : wcnt_q + WCNT_W'(1);
                        state_d = last_word ? ACCUM : LOAD_REF;
                    end
                end
                ACCUM: begin
                    if (!b_empty) begin
                        b_rden  = 1'b1;
                        acc_d   = acc_sat;
                        wcnt_d  = last_word ? '0 : wcnt_q + WCNT_W'(1);
                        state_d = last_word ? PUSH_DIST : ACCUM;
                    end else if (!b_open) begin
                        acc_d   = '0;
                        wcnt_d  = '0;
                        state_d = PUSH_BEST;
                    end
                end
                PUSH_DIST: begin
                    if (!res_full) begin
                        res_wren = 1'b1;
                        res_data = 32'(acc_q);
                        if (!minv_q || acc_q < min_q) begin
                            min_d  = acc_q;
                            best_d = idx_q;
                            minv_d = 1'b1;
                        end
                        idx_d   = &idx_q ? idx_q : idx_q + IDX_W'(1);
                        acc_d   = '0;
                        state_d = ACCUM;
                    end
                end
                PUSH_BEST: begin
                    if (!res_full) begin
                        res_wren                = 1'b1;
                        res_data[RES_BEST_FLAG] = 1'b1;
                        res_data[16 +: IDX_W]   = minv_q ? best_q : '1;
                        res_data[15:0]          = minv_q ? min16 : MIN16_SAT;
                        state_d                 = DONE;
                    end
                end
                DONE: done = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acc_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
            best_q  <= '0;
            minv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            minv_q  <= minv_d;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (a_rden) ref_ram[wcnt_q] <= a_data;
    end

endmodule

// File: tb/tb_face_match_sched.sv
// tb_face_match_sched: FIFO-modelled stimulus with a vector-level SAD/best-match model.
module tb_face_match_sched;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b0;
    logic        a_open = 1'b0, a_empty = 1'b1, a_rden;
    logic        b_open = 1'b0, b_empty = 1'b1, b_rden;
    logic [31:0] a_data = '0, b_data = '0;
    logic        res_open = 1'b0, res_full = 1'b0, res_wren, done;
    logic [31:0] res_data;

    logic [31:0] aq[$], bq[$], expq[$];
    logic [31:0] rq[$], cq[$];
    int          n_cmp = 0, n_fail = 0;

    face_match_sched #(.VEC_WORDS(4), .IDX_W(15)) dut (
        .bus_clk (bus_clk),
        .bus_rst (bus_rst),
        .a_open  (a_open),
        .a_empty (a_empty),
        .a_data  (a_data),
        .a_rden  (a_rden),
        .b_open  (b_open),
        .b_empty (b_empty),
        .b_data  (b_data),
        .b_rden  (b_rden),
        .res_open(res_open),
        .res_full(res_full),
        .res_wren(res_wren),
        .res_data(res_data),
        .done    (done)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result words straight from the vector rules: whole candidates only,
    // strict-less best, all-ones summary when nothing completed.
    task automatic model(input logic [31:0] r[$], input logic [31:0] c[$]);
        int best = -1;
        int mind = 0;
        for (int k = 0; k < c.size() / 4; k++) begin
            int d = 0;
            for (int w = 0; w < 4; w++) begin
                logic [31:0] cw = c[k*4+w];
                logic [31:0] rw = r[w];
                for (int y = 0; y < 4; y++) begin
                    int x = int'(cw[8*y +: 8]) - int'(rw[8*y +: 8]);
                    d += (x < 0) ? -x : x;
                end
            end
            expq.push_back(32'(d));
            if (best < 0 || d < mind) begin
                best = k;
                mind = d;
            end
        end
        if (best < 0) expq.push_back(32'hFFFF_FFFF);
        else expq.push_back({1'b1, 15'(best), (mind > 65535) ? 16'hFFFF : 16'(mind)});
    endtask

    // FWFT FIFO models: pop on the edge that ends a read cycle, present new head after it.
    always @(posedge bus_clk) begin
        logic [31:0] t;
        if (a_rden && aq.size() != 0) t = aq.pop_front();
        if (b_rden && bq.size() != 0) t = bq.pop_front();
        #1;
        a_empty = aq.size() == 0;
        a_data  = a_empty ? '0 : aq[0];
        b_empty = bq.size() == 0;
        b_data  = b_empty ? '0 : bq[0];
    end

    always @(negedge bus_clk) begin
        if (!bus_rst) begin
            if (a_rden) check("a_pop_nonempty", a_empty, 0);
            if (b_rden) check("b_pop_nonempty", b_empty, 0);
            if (res_wren) begin
                check("no_write_while_full", res_full, 0);
                check("write_expected", expq.size() != 0, 1);
                if (expq.size() != 0) check("res_data", res_data, expq.pop_front());
            end else begin
                check("res_data_idle_zero", res_data, 0);
            end
        end
    end

    task automatic session(input logic [31:0] r[$], input logic [31:0] c[$], input bit stall);
        int n;
        model(r, c);
        foreach (r[i]) aq.push_back(r[i]);
        foreach (c[i]) bq.push_back(c[i]);
        res_full = stall;
        a_open   = 1'b1;
        b_open   = 1'b1;
        res_open = 1'b1;
        if (stall) begin
            n = 0;
            while (bq.size() + 4 > c.size() && n < 300) begin
                @(negedge bus_clk);
                n++;
            end
            check("stall_reached", n < 300, 1);
            repeat (10) begin
                @(negedge bus_clk);
                check("stall_no_pop", bq.size(), c.size() - 4);
                check("stall_no_write", res_wren, 0);
            end
            res_full = 1'b0;
        end
        n = 0;
        while ((aq.size() != 0 || bq.size() != 0) && n < 300) begin
            @(negedge bus_clk);
            n++;
        end
        check("drain_timeout", n < 300, 1);
        b_open = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge bus_clk);
            n++;
        end
        check("done_high", done, 1);
        check("words_outstanding", expq.size(), 0);
        res_open = 1'b0;
        a_open   = 1'b0;
        repeat (2) @(negedge bus_clk);
        check("done_cleared", done, 0);
    endtask

    initial begin
        #1 bus_rst = 1'b1;
        #1;
        check("rst_a_rden", a_rden, 0);
        check("rst_b_rden", b_rden, 0);
        check("rst_res_wren", res_wren, 0);
        check("rst_res_data", res_data, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge bus_clk);
        bus_rst = 1'b0;

        rq = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
        cq = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010,
               32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020};
        model(rq, cq);
        check("pin_s1_w0", expq[0], 32'h00000000);
        check("pin_s1_w1", expq[1], 32'h00000100);
        check("pin_s1_w2", expq[2], 32'h80000000);
        expq.delete();
        session(rq, cq, 1'b0);

        rq = '{32'h0, 32'h0, 32'h0, 32'h0};
        cq = '{32'h00000032, 32'h0, 32'h0, 32'h0,
               32'h00000014, 32'h0, 32'h0, 32'h0,
               32'h14000000, 32'h0, 32'h0, 32'h0};
        model(rq, cq);
        check("pin_s2_w0", expq[0], 32'h00000032);
        check("pin_s2_best", expq[3], 32'h80010014);
        expq.delete();
        session(rq, cq, 1'b0);

        rq = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
        cq = '{32'h11121314, 32'h0F0E0D0C, 32'h10101010, 32'hFF000010,
               32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
        session(rq, cq, 1'b1);

        rq = '{32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080};
        cq = '{32'h80808081, 32'h80808081, 32'h80808081, 32'h80808081,
               32'h80808080, 32'h80808080};
        model(rq, cq);
        check("pin_s4_w0", expq[0], 32'h00000004);
        check("pin_s4_best", expq[1], 32'h80000004);
        expq.delete();
        session(rq, cq, 1'b0);

        cq.delete();
        model(rq, cq);
        check("pin_none_best", expq[0], 32'hFFFFFFFF);
        expq.delete();
        session(rq, cq, 1'b0);

        // Host abort mid-candidate: nothing written, nothing popped afterwards.
        rq = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
        foreach (rq[i]) aq.push_back(rq[i]);
        bq.push_back(32'h55555555);
        bq.push_back(32'h66666666);
        a_open = 1'b1; b_open = 1'b1; res_open = 1'b1;
        for (int n = 0; n < 300 && (aq.size() != 0 || bq.size() != 0); n++) @(negedge bus_clk);
        check("abort_drain", aq.size() + bq.size(), 0);
        res_open = 1'b0;
        @(negedge bus_clk);
        for (int i = 0; i < 4; i++) bq.push_back(32'h77777777);
        repeat (4) @(negedge bus_clk);
        check("abort_no_pop", bq.size(), 4);
        check("abort_no_write", expq.size(), 0);
        check("abort_done_low", done, 0);
        bq.delete();
        a_open = 1'b0; b_open = 1'b0;
        repeat (2) @(negedge bus_clk);
        rq = '{32'h0, 32'h0, 32'h0, 32'h0};
        cq = '{32'h00000032, 32'h0, 32'h0, 32'h0,
               32'h00000014, 32'h0, 32'h0, 32'h0,
               32'h14000000, 32'h0, 32'h0, 32'h0};
        session(rq, cq, 1'b0);

        // Reset mid reference load, then a fresh session must use only the new reference.
        aq.push_back(32'hFFFFFFFF);
        aq.push_back(32'hFFFFFFFF);
        a_open = 1'b1; res_open = 1'b1;
        for (int n = 0; n < 300 && aq.size() != 0; n++) @(negedge bus_clk);
        check("rst_mid_drain", aq.size(), 0);
        #2 bus_rst = 1'b1;
        #1;
        check("midrst_a_rden", a_rden, 0);
        check("midrst_res_wren", res_wren, 0);
        check("midrst_res_data", res_data, 0);
        check("midrst_done", done, 0);
        @(negedge bus_clk);
        bus_rst = 1'b0;
        rq = '{32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304};
        cq = '{32'h01020304, 32'h01020304, 32'h01020304, 32'h01020305,
               32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        session(rq, cq, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
